// File: rtl/uart_rx_oversampled.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_oversampled
//  Description : 8N1 UART receiver. Oversamples the line, qualifies the start
//                bit, takes a 2-of-3 vote on each bit, checks the stop bit and
//                presents each byte in a valid/ready holding register.
//
//  Ports
//    clk        in   system clock, rising edge
//    rst        in   asynchronous active-high reset
//    uart_rx    in   serial line, idle high, asynchronous to clk
//    rx_data    out  [7:0] received byte, stable while rx_valid=1
//    rx_valid   out  byte available in the holding register
//    rx_ready   in   consumer takes the byte when rx_valid && rx_ready
//    frame_err  out  1-clk pulse, stop bit sampled low
//    overrun    out  1-clk pulse, finished byte dropped (register full)
//    busy       out  receiver is inside a frame
//
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_oversampled #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int TICK_DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SAMP_W   = $clog2(OVERSAMPLE);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(OVERSAMPLE - 1);
  localparam logic [SAMP_W-1:0] SAMP_A    = SAMP_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SAMP_W-1:0] SAMP_B    = SAMP_W'(OVERSAMPLE / 2);
  localparam logic [SAMP_W-1:0] SAMP_VOTE = SAMP_W'(OVERSAMPLE / 2 + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_t;

  // Registered state
  logic              sync1_q, sync2_q;
  logic [1:0]        sync_vld_q;
  logic              armed_q;
  state_t            state_q;
  logic [TICK_W-1:0] tick_cnt_q;
  logic [SAMP_W-1:0] samp_cnt_q;
  logic [2:0]        bit_idx_q;
  logic              samp_a_q, samp_b_q, bit_q;
  logic [7:0]        shift_q;
  logic              done_q;
  logic [7:0]        rx_data_q;
  logic              rx_valid_q, frame_err_q, overrun_q, busy_q;

  // Next-state values
  logic              sync1_d, sync2_d;
  logic [1:0]        sync_vld_d;
  logic              armed_d;
  state_t            state_d;
  logic [TICK_W-1:0] tick_cnt_d;
  logic [SAMP_W-1:0] samp_cnt_d;
  logic [2:0]        bit_idx_d;
  logic              samp_a_d, samp_b_d, bit_d;
  logic [7:0]        shift_d;
  logic              done_d;
  logic [7:0]        rx_data_d;
  logic              rx_valid_d, frame_err_d, overrun_d, busy_d;

  logic w_line;
  logic w_tick;
  logic w_vote;
  logic w_bit_end;

  assign w_line    = sync2_q;
  assign w_tick    = (tick_cnt_q == TICK_LAST);
  // Third vote uses the live sample so the decision lands on the vote tick.
  assign w_vote    = (samp_a_q & samp_b_q) | (samp_a_q & w_line) | (samp_b_q & w_line);
  assign w_bit_end = w_tick && (samp_cnt_q == SAMP_LAST);

  always_comb begin
    sync1_d     = uart_rx;
    sync2_d     = sync1_q;
    // sync_vld marks when sync2 holds a real line sample rather than its
    // reset value, so a line held low through reset is never taken as high.
    sync_vld_d  = {sync_vld_q[0], 1'b1};
    armed_d     = armed_q;
    state_d     = state_q;
    tick_cnt_d  = w_tick ? '0 : tick_cnt_q + 1'b1;
    samp_cnt_d  = samp_cnt_q;
    bit_idx_d   = bit_idx_q;
    samp_a_d    = samp_a_q;
    samp_b_d    = samp_b_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    done_d      = 1'b0;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    if (w_tick) begin
      samp_cnt_d = (samp_cnt_q == SAMP_LAST) ? '0 : samp_cnt_q + 1'b1;
      if (samp_cnt_q == SAMP_A)    samp_a_d = w_line;
      if (samp_cnt_q == SAMP_B)    samp_b_d = w_line;
      if (samp_cnt_q == SAMP_VOTE) bit_d    = w_vote;
    end

    case (state_q)
      S_IDLE: begin
        // armed means the line has been seen high since the last frame, so
        // a low level here is a genuine falling edge.
        if (armed_q && !w_line) begin
          state_d    = S_START;
          tick_cnt_d = '0;
          samp_cnt_d = '0;
          armed_d    = 1'b0;
        end else if (sync_vld_q[1] && w_line) begin
          armed_d = 1'b1;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          if (!bit_q) begin
            state_d   = S_DATA;
            bit_idx_d = 3'd0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          shift_d   = {bit_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (w_tick && (samp_cnt_q == SAMP_VOTE)) begin
          if (w_vote) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (w_line) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Holding register: a new byte may replace one being consumed this clk.
    if (done_q) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      sync_vld_q  <= 2'b00;
      armed_q     <= 1'b0;
      state_q     <= S_IDLE;
      tick_cnt_q  <= '0;
      samp_cnt_q  <= '0;
      bit_idx_q   <= 3'd0;
      samp_a_q    <= 1'b1;
      samp_b_q    <= 1'b1;
      bit_q       <= 1'b1;
      shift_q     <= 8'h00;
      done_q      <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sync_vld_q  <= sync_vld_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      samp_cnt_q  <= samp_cnt_d;
      bit_idx_q   <= bit_idx_d;
      samp_a_q    <= samp_a_d;
      samp_b_q    <= samp_b_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      done_q      <= done_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: doc/uart_rx_oversampled.md
Name: uart_rx_oversampled

Overview:
- Standalone UART receiver for the serial side of the UART subsystem; it is the receive end of the 8N1 link that the transmit path drives.
- Oversamples the line at 16x baud, qualifies the start bit, majority-votes each bit, and checks the stop bit.
- Presents each received byte on a valid/ready holding register, with framing-error and overrun flags for the host side.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz
- BAUD_RATE, 115200, line rate in bit/s
- OVERSAMPLE, 16, sample ticks per bit; must be >= 8 and even

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- uart_rx  input  1  serial line, idle high, asynchronous to clk
- rx_data  output  8  received byte, stable while rx_valid=1
- rx_valid  output  1  byte available in holding register
- rx_ready  input  1  consumer accepts byte when rx_valid&&rx_ready at a clk edge
- frame_err  output  1  one-clk pulse: stop bit sampled 0
- overrun  output  1  one-clk pulse: completed byte dropped because holding register full
- busy  output  1  receiver is inside a frame (state != IDLE)

Behaviour:
- Reset values: rx_data=0x00, rx_valid=0, frame_err=0, overrun=0, busy=0; state=IDLE; synchroniser flops=1; tick counter=0.
- Sync: uart_rx passes through a 2-flop synchroniser before any use; this adds 2 clk of latency.
- Tick generator: TICK_DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), integer truncation (27 at defaults). A counter counts 0..TICK_DIV-1 and emits a 1-clk tick on terminal count.
  - The counter is cleared on start-edge detection, so bit phase aligns to the falling edge.
- Sampling: inside each bit, sample ticks run 0..OVERSAMPLE-1. Samples are taken at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The bit value is the 2-of-3 majority.
- IDLE:
  - On a synchronised 1->0 transition, go to START and clear the tick and sample counters.
  - A line held low out of reset or out of STOP recovery does not start a frame; a falling edge is required.
- START:
  - At tick OVERSAMPLE-1, if the majority is 0, go to DATA with bit index 0.
  - If the majority is 1, treat it as a glitch: return to IDLE, no flags.
- DATA:
  - 8 bits, LSB first, shifted into a shift register.
  - After bit 7 completes its OVERSAMPLE ticks, go to STOP.
- STOP, at the sample-vote tick (OVERSAMPLE/2+1), the receiver decides on the frame:
  - majority 1: the byte is complete; go to IDLE on the same decision.
  - majority 0: pulse frame_err for 1 clk, discard the byte, and go to WAIT_IDLE.
- WAIT_IDLE:
  - Remain until the synchronised line is 1, then go to IDLE. This handles break conditions.
- Byte completion, evaluated on the clk after the stop-bit decision:
  - rx_valid=0: load rx_data and set rx_valid=1.
  - rx_valid=1 and rx_ready=1 in the same clk: load the new byte; rx_valid stays 1. No overrun.
  - rx_valid=1 and rx_ready=0: pulse overrun for 1 clk, drop the new byte, keep rx_data unchanged.
- Handshake:
  - rx_valid falls on the clk after rx_valid&&rx_ready, unless a new byte loads in that same clk.
  - rx_data does not change while rx_valid=1 without a handshake.
- Latency: rx_valid rises within 1 clk of the stop-bit decision tick. That is ≈9.5 bit periods plus ≤3 clk after the line's falling edge.
- Flag exclusivity: frame_err and overrun never pulse in the same clk for the same frame.
  - A frame-errored byte never sets rx_valid and never causes overrun.
- Reset mid-frame: everything returns to reset values immediately, including a pending rx_valid.
  - After reset deasserts, a frame in progress is ignored until the line has been seen high and then falls again.
- busy=1 in START, DATA, STOP and WAIT_IDLE; busy=0 in IDLE.

Test Plan:
- Drive 8N1 byte 0x55 at 115200 baud (434 clk/bit at 50 MHz), with rx_ready=1 -> rx_valid pulses with rx_data=0x55 about 9.5 bit times after the start edge; frame_err=0 and overrun=0.
- Drive a low glitch of 3 ticks (81 clk) on an idle line -> receiver returns to IDLE; rx_valid, frame_err and overrun all stay 0; the next frame 0xA5 is received correctly.
- Drive frame 0x3C with stop bit forced 0, then line high -> frame_err pulses exactly 1 clk and rx_valid stays 0; a following 0x81 is received correctly.
- With rx_ready=0, send 0xA5 then 0x3C back-to-back -> rx_valid=1 with rx_data=0xA5; overrun pulses once at the 0x3C stop; rx_data stays 0xA5. Then raising rx_ready for 1 clk drops rx_valid.
- Send all 256 values back-to-back at 115200, with the bit period varied ±2%, and rx_ready=1 -> every byte received in order; no flags asserted.
- Assert rst during bit 4 of frame 0xF0 -> all outputs return to 0 and busy=0 immediately; after release and line idle, 0x0F is received correctly and no partial byte appears.
